rom_arbiter_rr: RTL
===================

Name: rom_arbiter_rr

Overview:
- 4-port round-robin arbiter sharing one ROM read port. It replaces fixed-priority ROM sharing wherever several engines fetch coefficients or code from the same ROM.
- Adds burst locking, so one port can keep the grant for several reads in a row.
- Adds a read-data return pipeline that routes a per-port data-valid strobe back to the requester RD_LATENCY cycles after its request is accepted.
- Sits between the requesting engines and the ROM wrapper (mem_rd/mem_addr/mem_accept/mem_d4rd).

Parameters:
ADDR_WIDTH, 10, ROM address width
DATA_WIDTH, 32, ROM data width
RD_LATENCY, 1, cycles from accepted request to mem_d4rd valid; legal 1..4
MAX_BURST, 4, maximum consecutive accepts one port may take while it holds the burst lock; legal 1..15

Ports:
clk  input  1  system clock, all state on rising edge
rst_b  input  1  asynchronous active-low reset
rd0..rd3  input  1 each  read request from port n, held until acceptN
addr0..addr3  input  ADDR_WIDTH each  read address from port n, stable while rdN is high
accept0..accept3  output  1 each  request from port n taken this cycle
dvalid0..dvalid3  output  1 each  data on data belongs to port n this cycle
data  output  DATA_WIDTH  read data shared by all ports; equals mem_d4rd
mem_rd  output  1  ROM read request
mem_addr  output  ADDR_WIDTH  ROM address
mem_accept  input  1  ROM takes the request this cycle
mem_d4rd  input  DATA_WIDTH  ROM read data, RD_LATENCY cycles after accept

Behaviour:
- State:
  - ptr[1:0]: highest-priority port, reset 0.
  - owner[1:0] and burst_cnt[3:0]: burst lock, reset owner=0 and burst_cnt=0 (unlocked).
  - tag pipe: RD_LATENCY stages of {v, id[1:0]}, reset all v=0.
- Grant (combinational):
  - If burst_cnt!=0 and rd[owner]=1, grant=owner.
  - Otherwise grant is the first requesting port, searching circularly from ptr upward (ptr, ptr+1, ... mod 4).
  - If no port requests, there is no grant.
- Memory side:
  - mem_rd = OR of rd0..rd3.
  - mem_addr = addr[grant]; mem_addr = 0 when there is no grant.
- Handshake:
  - acceptN = mem_accept & mem_rd & (grant==N); at most one accept is high per cycle.
  - While rst_b=0, all accept and dvalid outputs are 0.
- On a cycle with an accept, to port g:
  - If burst_cnt==0 or owner!=g: owner<=g, burst_cnt<=1.
  - Else burst_cnt<=burst_cnt+1.
  - If the new count reaches MAX_BURST: burst_cnt<=0 and ptr<=g+1 mod 4, which forces a round-robin step.
- Lock release without an accept:
  - If burst_cnt!=0 and rd[owner]=0: burst_cnt<=0 and ptr<=owner+1.
  - The lock drops the same cycle it is released, so another port can win that cycle.
- Unlocked accept: when burst_cnt was 0 before the accept and MAX_BURST>1, ptr is unchanged and the lock is set.
- MAX_BURST=1 gives pure round-robin: ptr<=g+1 on every accept.
- Tag pipe:
  - Stage0 <= {accept_any, g}; each later stage shifts forward every cycle with no stall.
  - dvalidN = last.v & (last.id==N), so dvalidN is high exactly RD_LATENCY cycles after acceptN.
  - Back-to-back accepts give back-to-back dvalids, in order.
- data is passed straight through from mem_d4rd and is not registered.
- mem_accept=0 while requests are pending: no state change except lock release; the grant may move if a request drops.
- Reset mid-operation: all tags are cleared and in-flight reads are dropped; no dvalid follows reset.
- Starvation bound: a continuously requesting port waits at most 3*MAX_BURST accepts.

Optional Feature:
ROM_ARB_PREEMPT_EN
- Defined: adds input preempt_en (1) and preempt_port (2).
  - While preempt_en=1 and rd[preempt_port]=1, grant=preempt_port regardless of lock or ptr.
  - These accepts do not change ptr, owner or burst_cnt.
  - Tags are generated as normal.
- Not defined: the ports are absent and arbitration is as above.

Test Plan:
- Reset, idle: rst_b low then high, all rd=0 -> mem_rd=0, accepts and dvalids 0, mem_addr=0.
- Pure RR: MAX_BURST=1, rd0..rd3 held high, mem_accept=1 -> accepts cycle 0,1,2,3,0.
  - mem_addr follows addr0..addr3 (e.g. 0x010,0x020,0x030,0x040).
  - dvalid pattern repeats the accept pattern 1 cycle later (RD_LATENCY=1).
- Burst lock: MAX_BURST=4, rd1 and rd2 held high -> accept1 x4, then accept2 x4, then accept1.
  - rd1 dropping after 2 accepts hands over to port 2 on that cycle.
- Backpressure: mem_accept toggling 1,0,0,1 with rd3 only -> accept3 only on the cycles mem_accept=1.
  - With RD_LATENCY=3, dvalid3 follows each accept3 exactly 3 cycles later.
- Reset mid-flight: RD_LATENCY=4, accept0 then rst_b low 2 cycles -> dvalid0 never asserted; ptr=0 after release.
- Preempt (macro defined): preempt_en=1, preempt_port=2, rd0 and rd2 high, lock owner 0 -> accept2 every cycle.
  - After preempt_en=0, port 0 resumes with its burst count unchanged.

Source files
------------

// File: rtl/rom_arbiter_rr.sv
// 4-port round-robin ROM read arbiter with burst lock and per-port data-valid return pipe.
// Latency: grant/accept combinational; dvalidN exactly RD_LATENCY cycles after acceptN.
// Backpressure: mem_accept=0 stalls all ports; requests stay pending.
// Optional fixed-port preemption when ROM_ARB_PREEMPT_EN is defined.
module rom_arbiter_rr #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  rd0,
    input  logic                  rd1,
    input  logic                  rd2,
    input  logic                  rd3,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [ADDR_WIDTH-1:0] addr3,
    output logic                  accept0,
    output logic                  accept1,
    output logic                  accept2,
    output logic                  accept3,
    output logic                  dvalid0,
    output logic                  dvalid1,
    output logic                  dvalid2,
    output logic                  dvalid3,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
`ifdef ROM_ARB_PREEMPT_EN
    input  logic                  preempt_en,
    input  logic [1:0]            preempt_port,
`endif
    input  logic                  mem_accept,
    input  logic [DATA_WIDTH-1:0] mem_d4rd
);

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    logic [3:0]            req;
    logic [ADDR_WIDTH-1:0] addr_arr [4];

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cnt_nx;

    logic       lock_hit;
    logic       rr_vld;
    logic [1:0] rr_id;
    logic       pre_hit;
    logic [1:0] pre_port;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       acc_any;
    logic [3:0] acc_vec;

    logic [RD_LATENCY-1:0] tag_v_q;
    logic [1:0]            tag_id_q [RD_LATENCY];

    assign req         = {rd3, rd2, rd1, rd0};
    assign addr_arr[0] = addr0;
    assign addr_arr[1] = addr1;
    assign addr_arr[2] = addr2;
    assign addr_arr[3] = addr3;

`ifdef ROM_ARB_PREEMPT_EN
    assign pre_hit  = preempt_en & req[preempt_port];
    assign pre_port = preempt_port;
`else
    assign pre_hit  = 1'b0;
    assign pre_port = 2'd0;
`endif

    assign lock_hit = (cnt_q != 4'd0) && req[owner_q];

    // Circular search from ptr: walk offsets high to low so the nearest requester wins.
    always_comb begin
        rr_vld = 1'b0;
        rr_id  = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                rr_vld = 1'b1;
                rr_id  = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        grant_vld = rr_vld;
        grant_id  = rr_id;
        if (pre_hit) begin
            grant_vld = 1'b1;
            grant_id  = pre_port;
        end else if (lock_hit) begin
            grant_vld = 1'b1;
            grant_id  = owner_q;
        end
    end

    assign mem_rd   = |req;
    assign mem_addr = grant_vld ? addr_arr[grant_id] : '0;
    assign acc_any  = rst_b & mem_accept & mem_rd & grant_vld;

    always_comb begin
        acc_vec = 4'b0000;
        if (acc_any) acc_vec[grant_id] = 1'b1;
    end

    assign accept0 = acc_vec[0];
    assign accept1 = acc_vec[1];
    assign accept2 = acc_vec[2];
    assign accept3 = acc_vec[3];

    // Release first; a same-cycle accept then overrides owner/count as needed.
    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cnt_nx  = 4'd1;
        if ((cnt_q != 4'd0) && !req[owner_q]) begin
            cnt_d = 4'd0;
            ptr_d = owner_q + 2'd1;
        end
        if (acc_any && !pre_hit) begin
            if ((cnt_q == 4'd0) || (owner_q != grant_id)) cnt_nx = 4'd1;
            else                                          cnt_nx = cnt_q + 4'd1;
            owner_d = grant_id;
            if (cnt_nx == MAXB) begin
                cnt_d = 4'd0;
                ptr_d = grant_id + 2'd1;
            end else begin
                cnt_d = cnt_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_v_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_id_q[i] <= 2'd0;
        end else begin
            tag_v_q[0]  <= acc_any;
            tag_id_q[0] <= grant_id;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign dvalid0 = rst_b & tag_v_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == 2'd0);
    assign dvalid1 = rst_b & tag_v_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == 2'd1);
    assign dvalid2 = rst_b & tag_v_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == 2'd2);
    assign dvalid3 = rst_b & tag_v_q[RD_LATENCY-1] & (tag_id_q[RD_LATENCY-1] == 2'd3);

    assign data = mem_d4rd;

endmodule
